// File: rtl/max_search_pkg.sv
// rtl/max_search_pkg.sv - shared types and defaults for the max search controller
package max_search_pkg;

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  localparam int DEFAULT_WIDTH = 2;
  localparam int DEFAULT_COUNT = 4;

endpackage

// File: rtl/max_search_gt_cmp.sv
// rtl/max_search_gt_cmp.sv - combinational unsigned greater-than comparator (module gt_cmp)
module gt_cmp #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             res
);

  assign res = (a > b);

endmodule

// File: rtl/max_search_ctrl.sv
// rtl/max_search_ctrl.sv - time-shared comparator finding the max of a COUNT-operand burst
// Optional MAX_SEARCH_MIN_EN adds a second comparator tracking the burst minimum.
module max_search_ctrl
  import max_search_pkg::*;
#(
  parameter int  WIDTH = DEFAULT_WIDTH,
  parameter int  COUNT = DEFAULT_COUNT,
  localparam int IDXW  = $clog2(COUNT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [IDXW-1:0]  out_idx
`ifdef MAX_SEARCH_MIN_EN
  ,
  output logic [WIDTH-1:0] out_min,
  output logic [IDXW-1:0]  out_min_idx
`endif
);

  state_t           state, state_nxt;
  logic [IDXW:0]    count;
  logic [WIDTH-1:0] max_q;
  logic [IDXW-1:0]  idx_q;
  logic             accept;
  logic             last;
  logic             max_gt;

  assign accept = (state == COLLECT) && in_valid;
  assign last   = (count == (IDXW+1)'(COUNT - 1));

  gt_cmp #(.WIDTH(WIDTH)) u_max_cmp (
    .a   (in_data),
    .b   (max_q),
    .res (max_gt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)                  state_nxt = COLLECT;
      COLLECT: if (accept && last)         state_nxt = DONE;
      DONE:    if (out_ready)              state_nxt = IDLE;
      default:                             state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    in_ready  = (state == COLLECT);
    out_valid = (state == DONE);
  end

  assign out_max = max_q;
  assign out_idx = idx_q;

  // The first operand seeds the tracker; later ones replace it only when strictly greater.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      max_q <= '0;
      idx_q <= '0;
    end else if (state == IDLE && start) begin
      count <= '0;
    end else if (accept) begin
      count <= count + 1'b1;
      if (count == '0 || max_gt) begin
        max_q <= in_data;
        idx_q <= count[IDXW-1:0];
      end
    end
  end

`ifdef MAX_SEARCH_MIN_EN
  logic [WIDTH-1:0] min_q;
  logic [IDXW-1:0]  min_idx_q;
  logic             min_gt;

  gt_cmp #(.WIDTH(WIDTH)) u_min_cmp (
    .a   (min_q),
    .b   (in_data),
    .res (min_gt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q     <= '0;
      min_idx_q <= '0;
    end else if (accept && (count == '0 || min_gt)) begin
      min_q     <= in_data;
      min_idx_q <= count[IDXW-1:0];
    end
  end

  assign out_min     = min_q;
  assign out_min_idx = min_idx_q;
`endif

endmodule

// File: doc/max_search_ctrl.md
Name: max_search_ctrl

Overview:
- Sequential controller that time-shares one unsigned greater-than comparator to find the maximum of a burst of COUNT operands.
- Operands arrive over a valid/ready stream; the result is returned over a second valid/ready stream.
- Sits directly above the 2-bit greater-than datapath; it is the first clocked user of that comparator in the digital-logic tree.

Parameters:
- WIDTH, 2, operand width in bits; legal range 1..16.
- COUNT, 4, operands per burst; legal range 2..256.
- IDXW, $clog2(COUNT), width of the index output; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a burst.
- busy  output  1  high whenever state is not IDLE.
- in_valid  input  1  operand valid.
- in_ready  output  1  controller can accept an operand.
- in_data  input  WIDTH  unsigned operand.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_max  output  WIDTH  largest operand in the burst.
- out_idx  output  IDXW  arrival position of out_max, starting at 0.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; count, max_q, idx_q cleared to 0; busy=0, in_ready=0, out_valid=0, out_max=0, out_idx=0. Takes effect immediately, even mid-burst; the partial burst is discarded and no result is produced.
- FSM states: IDLE, COLLECT, DONE. All outputs are driven from state and registers; nothing is combinational from inputs.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 moves the FSM to COLLECT on the next edge and clears count.
- COLLECT:
  - in_ready=1, busy=1; start is ignored.
  - Accept occurs on in_valid&in_ready.
  - When count==0, an accept loads max_q=in_data and idx_q=0 unconditionally.
  - When count>0, an accept loads max_q=in_data and idx_q=count only if gt(in_data, max_q) is true. Compare is strictly greater, so on ties the earliest index is kept.
  - Every accept increments count.
  - An accept with count==COUNT-1 moves the FSM to DONE on that edge.
- DONE:
  - out_valid=1, in_ready=0.
  - out_max=max_q and out_idx=idx_q, held stable until the handshake.
  - The handshake (out_valid&out_ready) moves the FSM to IDLE.
  - start is ignored in DONE, including in the handshake cycle.
- Latency: out_valid rises on the edge that accepts the last operand, so it is visible the cycle after the final accept. Minimum burst time is COUNT+2 cycles from start to IDLE.
- in_valid gaps in COLLECT stall the count; there is no timeout.
- in_data is ignored whenever there is no accept.
- Width rule: the comparison is unsigned WIDTH-bit with no sign extension. count is IDXW+1 bits wide, so no wrap occurs before COUNT.

Optional Feature:
- Macro: MAX_SEARCH_MIN_EN.
- When defined:
  - Adds outputs out_min (WIDTH) and out_min_idx (IDXW).
  - Tracked with a second comparator instance, gt(min_q, in_data): a strictly smaller operand replaces min_q, and ties keep the earliest index.
  - Loaded and reset exactly like max_q and idx_q.
  - Valid under the same out_valid.
- When undefined: the ports and the second comparator instance do not exist, and the behaviour above is unchanged.

Decomposition:
- Package max_search_pkg holds:
  - typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
  - localparam defaults for WIDTH and COUNT.
- One sub-module: gt_cmp.
  - Parameterised WIDTH, purely combinational.
  - Ports a, b, res; res=1 iff a>b unsigned.
  - Generalises the existing 2-bit greater-than circuit and is instantiated once, or twice with MAX_SEARCH_MIN_EN.

Test Plan (WIDTH=2, COUNT=4):
- Reset, then start; stream 1,3,0,2 with in_valid held high and out_ready=1 → out_valid one cycle after the 4th accept, out_max=3, out_idx=1; FSM back in IDLE the next cycle.
- Ties: stream 2,3,3,1 → out_max=3, out_idx=1; stream 0,0,0,0 → out_max=0, out_idx=0.
- Backpressure and gaps: stream 3,1,2,3 with in_valid deasserted for 2 cycles between each operand, out_ready held low 5 cycles → result stays stable at out_max=3, out_idx=0 throughout; exactly one handshake occurs.
- Reset mid-burst: rst_n pulsed low after the 2nd accept → immediately busy=0, in_ready=0, out_valid=0; a following burst 0,1,2,3 returns out_max=3, out_idx=3.
- start asserted during COLLECT and during the DONE handshake cycle → ignored: no count reset, FSM lands in IDLE with busy=0.
- With MAX_SEARCH_MIN_EN defined, stream 2,0,3,0 → out_max=3/out_idx=2 and out_min=0/out_min_idx=1.
